uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  UART 8N1 receiver. Sits directly downstream of the baud generator and is its only client.
//  - Detects the start-bit falling edge on the serial line and requests baud timing via bps_start.
//  - Samples each bit on the mid-bit clk_bps pulse and assembles the data byte.
//  - Presents the byte with a one-cycle valid strobe, or flags a framing error.
// PARAMETERS
//  DATA_BITS    8   data bits per frame, LSB first (range 5..8)
//  SYNC_STAGES  2   flops in the rs232_rx metastability synchroniser (>=2)
// PORTS
//  clk        in   1          system clock, 50 MHz
//  rst        in   1          asynchronous, active-high reset
//  rs232_rx   in   1          asynchronous serial line, idle high
//  clk_bps    in   1          one-cycle mid-bit sample pulse from the baud generator
//  bps_start  out  1          high while a frame is in progress; low clears the baud counter
//  rx_data    out  DATA_BITS  last good byte; held until the next good frame
//  rx_valid   out  1          one-cycle strobe, rx_data updated this cycle
//  frame_err  out  1          one-cycle strobe, stop bit sampled low
//  rx_busy    out  1          high in any state other than IDLE
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - State goes to IDLE.
//    - bps_start, rx_valid, frame_err and rx_busy are 0; rx_data is 0.
//    - Shift register and bit counter are 0.
//    - Synchroniser flops preset to 1 (idle line).
//  - Input conditioning: rs232_rx passes through SYNC_STAGES flops. One more flop keeps the previous
//    value. A falling edge (prev=1, cur=0) is a one-cycle pulse.
//  - FSM states: IDLE, START, DATA, STOP. Binary encoded, 2 bits.
//  - IDLE
//    - Falling edge -> START; bps_start set to 1 on that same edge.
//    - Otherwise stay in IDLE.
//  - START
//    - On clk_bps with synced rx==0 -> DATA; bit_cnt = 0.
//    - On clk_bps with rx==1 (glitch) -> IDLE; bps_start = 0; no strobe.
//  - DATA
//    - On each clk_bps: shift = {rx, shift[DATA_BITS-1:1]} (LSB first); bit_cnt++.
//    - After sample DATA_BITS-1 -> STOP.
//  - STOP, on clk_bps:
//    - rx==1: rx_data <= shift; rx_valid = 1 for one cycle.
//    - rx==0: frame_err = 1 for one cycle; rx_data unchanged.
//    - Either way -> IDLE and bps_start = 0.
//  - Re-arm: IDLE holds bps_start low for at least 1 cycle before a new edge is accepted, so the
//    baud counter always restarts from 0.
//  - Falling edges outside IDLE are ignored.
//  - A start edge that arrives while the STOP sample is being taken is lost. Senders must provide
//    at least 1/2 bit of idle, which a full stop bit guarantees.
//  - clk_bps is ignored in IDLE.
//  - rx_valid and frame_err are never high together. Each is a single-cycle pulse.
//  - Latency: strobe is registered 1 cycle after the stop-bit clk_bps. At 9600 bps/50 MHz that is
//    about 9.5 bit times (about 49.5k clk) after the start edge.
//  - bit_cnt width: $clog2(DATA_BITS). No wrap: it is cleared on entry to DATA.
//  - Reset mid-frame: immediate return to reset values. The partial byte is discarded and
//    rx_data is cleared.
//  - rx_busy = (state != IDLE), registered.
// STRUCTURE
//  - Shared package/include uart_defs.vh:
//    - State encodings ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3.
//    - UART_DATA_BITS default 8.
//    - Baud divider constants; these are also used by the baud generator.
//  - One sub-module: rx_sync_edge (parameter SYNC_STAGES).
//    - Reset value 1.
//    - Outputs rx_s (synced level) and rx_fall (one-cycle falling-edge pulse).
//  - FSM, shift register and output registers stay in uart_rx_frame.
// TESTING
//  - Bench setup: instantiate with the baud generator at 9600 bps (5208 clk/bit); drive bytes from a
//    bit-accurate serial model.
//  - Frame 0x55 with stop=1 -> one rx_valid pulse, rx_data=8'h55, frame_err stays 0, bps_start
//    low within 1 cycle of the stop sample.
//  - rs232_rx low for 100 clk, then high -> START rejects at the first clk_bps; bps_start returns
//    to 0, no rx_valid, no frame_err.
//  - 0xA5 after good 0x3C, but stop bit driven 0 -> frame_err pulse, rx_data stays 8'h3C,
//    rx_valid stays 0.
//  - Back-to-back 0x00 then 0xFF, one stop bit each -> two rx_valid pulses with rx_data 8'h00
//    then 8'hFF; bps_start low for >=1 cycle between them.
//  - rst pulse while DATA samples bit 3 -> all outputs 0, FSM in IDLE; next frame 0x3C yields
//    rx_data=8'h3C, rx_valid=1.
//  - Check throughout: rx_valid and frame_err are never high together, and each is high for
//    exactly 1 cycle.

Source files
------------

// File: rtl/uart_rx_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_pkg
// Description : Shared UART definitions: FSM encodings, frame width, baud constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_frame_pkg;

    localparam int UART_DATA_BITS = 8;

    // Baud divider constants, shared with the baud generator
    localparam int UART_CLK_HZ    = 50_000_000;
    localparam int UART_BAUD      = 9600;
    localparam int UART_BPS_DIV   = UART_CLK_HZ / UART_BAUD;
    localparam int UART_BPS_HALF  = UART_BPS_DIV / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame_sync.sv
`default_nettype none
// ============================================================================
// Module      : rx_sync_edge
// Description : Serial-line synchroniser with one-cycle falling-edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rs232_rx,
    output logic rx_s,
    output logic rx_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Preset high so reset looks like an idle line and never fakes a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rs232_rx};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rx_s    = r_sync[SYNC_STAGES-1];
    assign rx_fall = r_prev & ~rx_s;

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame
// Description : UART 8N1 receiver; requests baud timing, samples mid-bit, strobes byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rs232_rx,
    input  logic                 clk_bps,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(DATA_BITS);

    rx_state_t            r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [CNT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic                 w_bps_start_nxt;
    logic                 w_valid_nxt;
    logic                 w_err_nxt;
    logic                 w_load_data;
    logic                 w_rx_s;
    logic                 w_rx_fall;

    rx_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .rs232_rx (rs232_rx),
        .rx_s     (w_rx_s),
        .rx_fall  (w_rx_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            bps_start <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            bps_start <= w_bps_start_nxt;
            rx_valid  <= w_valid_nxt;
            frame_err <= w_err_nxt;
            rx_busy   <= (w_state_nxt != ST_IDLE);
            if (w_load_data) begin
                rx_data <= r_shift;
            end
        end
    end

    // bps_start is already low on arrival in IDLE, giving the baud counter a clear cycle
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_bps_start_nxt = bps_start;
        w_valid_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
        w_load_data     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_bps_start_nxt = 1'b0;
                if (w_rx_fall) begin
                    w_state_nxt     = ST_START;
                    w_bps_start_nxt = 1'b1;
                end
            end
            ST_START: begin
                if (clk_bps) begin
                    if (!w_rx_s) begin
                        w_state_nxt   = ST_DATA;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_state_nxt     = ST_IDLE;
                        w_bps_start_nxt = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (clk_bps) begin
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (clk_bps) begin
                    w_state_nxt     = ST_IDLE;
                    w_bps_start_nxt = 1'b0;
                    if (w_rx_s) begin
                        w_valid_nxt = 1'b1;
                        w_load_data = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_bps_start_nxt = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frame
// Description : Scoreboard bench for uart_rx_frame with a shortened bit period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

    localparam int BIT_CLKS = 32;
    localparam int HALF     = BIT_CLKS / 2;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rs232_rx;
    logic       clk_bps;
    logic       bps_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    logic [7:0] r_bcnt;
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic       prev_v = 1'b0;
    logic       prev_e = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #10 clk = ~clk;

    // Baud generator model: counter held clear while bps_start is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt  <= '0;
            clk_bps <= 1'b0;
        end else begin
            if (!bps_start || r_bcnt == 8'(BIT_CLKS - 1)) r_bcnt <= '0;
            else                                          r_bcnt <= r_bcnt + 8'd1;
            clk_bps <= bps_start && (r_bcnt == 8'(HALF));
        end
    end

    uart_rx_frame #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs232_rx  (rs232_rx),
        .clk_bps   (clk_bps),
        .bps_start (bps_start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops an expectation on every strobe
    always @(negedge clk) begin
        if (prev_v) check("rx_valid_width", 32'(rx_valid), 32'd0);
        if (prev_e) check("frame_err_width", 32'(frame_err), 32'd0);
        if (rx_valid || frame_err) begin
            check("strobe_exclusive", 32'(rx_valid & frame_err), 32'd0);
            check("bps_start_after_stop", 32'(bps_start), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe valid=%0b err=%0b data=%0h", rx_valid, frame_err, rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_kind", 32'(frame_err), 32'(mon_e.is_err));
                check("rx_data", 32'(rx_data), 32'(mon_e.data));
            end
        end
        prev_v <= rx_valid;
        prev_e <= frame_err;
    end

    task automatic hold_bit(input logic v);
        rs232_rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop);
        rs232_rx = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag, input logic [7:0] data_req);
        check({tag, "_bps_start"}, 32'(bps_start), 32'd0);
        check({tag, "_rx_busy"},   32'(rx_busy),   32'd0);
        check({tag, "_rx_valid"},  32'(rx_valid),  32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_rx_data"},   32'(rx_data),   32'(data_req));
    endtask

    initial begin
        rst      = 1'b1;
        rs232_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        exp_q.push_back('{is_err: 1'b0, data: 8'h55});
        send_byte(8'h55, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);

        // Short low glitch: START must reject it at the first sample
        rs232_rx = 1'b0;
        repeat (6) @(negedge clk);
        check("glitch_bps_start_raised", 32'(bps_start), 32'd1);
        repeat (2) @(negedge clk);
        rs232_rx = 1'b1;
        repeat (40) @(negedge clk);
        check_idle_outputs("glitch", 8'h55);

        exp_q.push_back('{is_err: 1'b0, data: 8'h3C});
        send_byte(8'h3C, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        exp_q.push_back('{is_err: 1'b1, data: 8'h3C});
        send_byte(8'hA5, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);

        exp_q.push_back('{is_err: 1'b0, data: 8'h00});
        exp_q.push_back('{is_err: 1'b0, data: 8'hFF});
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);

        // Reset asserted around the bit-3 sample of frame 0x81
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        hold_bit(1'b0);
        rs232_rx = 1'b0;
        repeat (HALF + 4) @(negedge clk);
        check("midframe_rx_busy", 32'(rx_busy), 32'd1);
        rst      = 1'b1;
        rs232_rx = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("midframe_reset", 8'h00);
        rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check_idle_outputs("post_reset_idle", 8'h00);

        exp_q.push_back('{is_err: 1'b0, data: 8'h3C});
        send_byte(8'h3C, 1'b1);

        for (int i = 0; i < 4 * BIT_CLKS && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("final_rx_data", 32'(rx_data), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
